prt_fald_dds_ctl: RTL

- Per-frame sequencer that fills the FALD driver dimming RAM through its dimming data stream (DDS) port.
- On each Vsync rising edge it fetches one brightness word per zone from an upstream zone-statistics buffer using a single-outstanding request/response handshake.
- Each word is scaled by a gain, saturated and floored to a minimum, then streamed as DDS_INIT / DDS_DAT / DDS_VLD.
- Runs in the video clock domain alongside the driver.

---
 rtl/prt_fald_dds_ctl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/prt_fald_dds_ctl.sv
// prt_fald_dds_ctl: per-frame FALD dimming-RAM fill sequencer.
// On each Vsync rising edge, reads one brightness word per zone from the
// zone-statistics buffer, applies gain, saturation and a floor, and streams
// the result out as DDS_INIT / DDS_DAT / DDS_VLD.
// Optional feature macro: PRT_FALD_DDS_TMO_EN adds a WAIT-state watchdog
// and the sticky STA_TMO_OUT status port.
//
// state | meaning
// IDLE  | waiting for run & Vsync rising edge
// INIT  | DDS init pulse, shadow zones/gain, clear zone counter
// REQ   | one-cycle source read request for current zone
// WAIT  | waiting for source data valid
// CALC  | scale/saturate/floor; result registered onto the DDS port
// DONE  | frame complete, bump frame counter
module prt_fald_dds_ctl #(
  parameter int P_DAT_WIDTH = 16,
  parameter int P_MAX_ZONES = 2048
) (
  input  logic                           SYS_CLK_IN,
  input  logic                           SYS_RST_IN,
  input  logic                           CTL_RUN_IN,
  input  logic [15:0]                    CTL_ZONES_IN,
  input  logic [7:0]                     CTL_GAIN_IN,
  input  logic [P_DAT_WIDTH-1:0]         CTL_MIN_IN,
  input  logic                           VID_VS_IN,
  output logic                           SRC_REQ_OUT,
  output logic [$clog2(P_MAX_ZONES)-1:0] SRC_ADR_OUT,
  input  logic [P_DAT_WIDTH-1:0]         SRC_DAT_IN,
  input  logic                           SRC_VLD_IN,
  output logic                           DDS_INIT_OUT,
  output logic [P_DAT_WIDTH-1:0]         DDS_DAT_OUT,
  output logic                           DDS_VLD_OUT,
  output logic                           STA_BUSY_OUT,
  output logic                           STA_OVR_OUT,
  output logic [7:0]                     STA_FRM_OUT
`ifdef PRT_FALD_DDS_TMO_EN
  ,
  output logic                           STA_TMO_OUT
`endif
);

  localparam int AW = $clog2(P_MAX_ZONES);
  localparam int PW = P_DAT_WIDTH + 8;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_REQ, S_WAIT, S_CALC, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic                   vs_d;
  logic                   vs_re;
  logic [11:0]            zone_cnt;
  logic [11:0]            zones_sh;
  logic [11:0]            zones_clamp;
  logic [7:0]             gain_sh;
  logic [P_DAT_WIDTH-1:0] dat_q;
  logic [P_DAT_WIDTH-1:0] dds_dat_q;
  logic                   dds_vld_q;
  logic                   sta_ovr;
  logic [7:0]             sta_frm;
  logic [PW-5:0]          prod_q4;
  logic [P_DAT_WIDTH-1:0] scaled;
  logic [P_DAT_WIDTH-1:0] calc_out;
  logic                   emit;
  logic                   tmo_tc;

  assign vs_re       = VID_VS_IN & ~vs_d;
  assign zones_clamp = (CTL_ZONES_IN > 16'(P_MAX_ZONES)) ? 12'(P_MAX_ZONES) : CTL_ZONES_IN[11:0];

  // gain is 4.4 fixed point: drop the 4 fraction bits, saturate on integer overflow
  assign prod_q4  = (PW-4)'((PW'(dat_q) * PW'(gain_sh)) >> 4);
  assign scaled   = (|prod_q4[PW-5:P_DAT_WIDTH]) ? '1 : prod_q4[P_DAT_WIDTH-1:0];
  assign calc_out = (scaled < CTL_MIN_IN) ? CTL_MIN_IN : scaled;
  // an abort or run drop during CALC discards that zone's result
  assign emit     = CTL_RUN_IN & (state == S_CALC) & ~vs_re;

`ifdef PRT_FALD_DDS_TMO_EN
  logic [7:0] wdg;
  logic       sta_tmo;

  // watchdog: loaded in REQ, counts down through WAIT; terminal on the 255th WAIT cycle
  always_ff @(posedge SYS_CLK_IN or posedge SYS_RST_IN) begin
    if (SYS_RST_IN) begin
      wdg     <= '0;
      sta_tmo <= 1'b0;
    end else begin
      if (state == S_REQ)
        wdg <= 8'd255;
      else if (state == S_WAIT && wdg != 8'd0)
        wdg <= wdg - 8'd1;
      if (!CTL_RUN_IN)
        sta_tmo <= 1'b0;
      else if (tmo_tc)
        sta_tmo <= 1'b1;
    end
  end

  assign tmo_tc      = (state == S_WAIT) & ~SRC_VLD_IN & (wdg == 8'd1);
  assign STA_TMO_OUT = sta_tmo;
`else
  assign tmo_tc = 1'b0;
`endif

  // state register
  always_ff @(posedge SYS_CLK_IN or posedge SYS_RST_IN) begin
    if (SYS_RST_IN) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // next-state: run drop beats everything, then Vsync abort while busy
  always_comb begin
    state_nxt = state;
    if (!CTL_RUN_IN) begin
      state_nxt = S_IDLE;
    end else if (vs_re && state != S_IDLE) begin
      state_nxt = S_INIT;
    end else begin
      case (state)
        S_IDLE: if (vs_re) state_nxt = S_INIT;
        S_INIT: state_nxt = (zones_clamp == 12'd0) ? S_DONE : S_REQ;
        S_REQ:  state_nxt = S_WAIT;
        S_WAIT: if (SRC_VLD_IN || tmo_tc) state_nxt = S_CALC;
        S_CALC: state_nxt = (zone_cnt + 12'd1 == zones_sh) ? S_DONE : S_REQ;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Moore strobes, all gated off as soon as run drops
  always_comb begin
    SRC_REQ_OUT  = CTL_RUN_IN & (state == S_REQ);
    DDS_INIT_OUT = CTL_RUN_IN & (state == S_INIT);
    DDS_VLD_OUT  = CTL_RUN_IN & dds_vld_q;
    STA_BUSY_OUT = (state != S_IDLE);
  end

  // datapath, zone counter, shadows and status
  always_ff @(posedge SYS_CLK_IN or posedge SYS_RST_IN) begin
    if (SYS_RST_IN) begin
      vs_d      <= 1'b0;
      zone_cnt  <= '0;
      zones_sh  <= '0;
      gain_sh   <= '0;
      dat_q     <= '0;
      dds_dat_q <= '0;
      dds_vld_q <= 1'b0;
      sta_ovr   <= 1'b0;
      sta_frm   <= '0;
    end else begin
      vs_d <= VID_VS_IN;
      if (state == S_INIT) begin
        zone_cnt <= '0;
        zones_sh <= zones_clamp;
        gain_sh  <= CTL_GAIN_IN;
      end else if (state == S_CALC) begin
        zone_cnt <= zone_cnt + 12'd1;
      end
      if (state == S_WAIT && SRC_VLD_IN)
        dat_q <= SRC_DAT_IN;
      else if (tmo_tc)
        dat_q <= '0;
      dds_vld_q <= emit;
      if (emit)
        dds_dat_q <= calc_out;
      if (!CTL_RUN_IN)
        sta_ovr <= 1'b0;
      else if (vs_re && state != S_IDLE)
        sta_ovr <= 1'b1;
      if (CTL_RUN_IN && state == S_DONE && !vs_re)
        sta_frm <= sta_frm + 8'd1;
    end
  end

  assign SRC_ADR_OUT = zone_cnt[AW-1:0];
  assign DDS_DAT_OUT = dds_dat_q;
  assign STA_OVR_OUT = sta_ovr;
  assign STA_FRM_OUT = sta_frm;

endmodule
